seg_scan_driver: RTL

//   Downstream consumer of the mypio_0 seg_output[11:0] conduit. Treats the 12-bit word as three
//   hex nibbles and time-multiplexes them onto a 3-digit 7-segment display on the GPIO header.

---
 rtl/seg_scan_driver_if.sv | 9 +
 rtl/seg_scan_driver.sv | 58 +++++
 2 files changed

// File: rtl/seg_scan_driver_if.sv
// seg_scan_driver_if: hex word in, multiplexed 7-segment drive and frame pulse out
interface seg_scan_driver_if;
    logic [11:0] seg_value;
    logic [6:0]  seg;
    logic [2:0]  dig;
    logic        frame_tick;
    modport master (output seg_value, input seg, dig, frame_tick);
    modport slave  (input seg_value, output seg, dig, frame_tick);
endinterface

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: 3-digit time-multiplexed 7-segment driver with frame-coherent snapshot
// Define SEG_LZ_SUPPRESS_EN to blank leading zeros of digits 2 and 1.
module seg_scan_driver #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int ACTIVE_LOW   = 1
) (
    input logic clk_clk,
    input logic reset_reset_n,
    seg_scan_driver_if.slave bus
);
    localparam int cw = $clog2(SCAN_DIV);
    localparam logic inv = ACTIVE_LOW != 0;
    localparam logic [6:0] hex_tab [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };
    logic [cw-1:0] cnt;
    logic [1:0]    idx;
    logic [11:0]   snap, snap_nx;
    logic [6:0]    seg_q, seg_nx;
    logic [2:0]    dig_q, dig_nx;
    logic [3:0]    nib;
    logic          tick, last, blank, sup;
    // Decode from the value being captured this cycle so slot0 never shows the stale frame
    always_comb begin
        tick    = cnt == '0 && idx == 2'd0;
        last    = cnt == cw'(SCAN_DIV - 1);
        blank   = cnt < cw'(BLANK_CYCLES);
        snap_nx = tick ? bus.seg_value : snap;
        nib     = idx == 2'd2 ? snap_nx[11:8] : idx == 2'd1 ? snap_nx[7:4] : snap_nx[3:0];
`ifdef SEG_LZ_SUPPRESS_EN
        sup     = (idx == 2'd2 && snap_nx[11:8] == 4'd0) || (idx == 2'd1 && snap_nx[11:4] == 8'd0);
`else
        sup     = 1'b0;
`endif
        seg_nx  = sup ? {7{inv}} : hex_tab[nib] ^ {7{inv}};
        dig_nx  = (blank || sup) ? {3{inv}} : (3'b001 << idx) ^ {3{inv}};
    end
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            cnt   <= '0;
            idx   <= 2'd0;
            snap  <= '0;
            seg_q <= {7{inv}};
            dig_q <= {3{inv}};
        end else begin
            cnt   <= last ? '0 : cnt + cw'(1);
            if (last) idx <= idx == 2'd2 ? 2'd0 : idx + 2'd1;
            snap  <= snap_nx;
            if (blank) seg_q <= seg_nx;
            dig_q <= dig_nx;
        end
    end
    assign bus.seg        = seg_q;
    assign bus.dig        = dig_q;
    assign bus.frame_tick = reset_reset_n && tick;
endmodule
